// File: rtl/clip_recorder_if.sv
// rtl/clip_recorder_if.sv - capture, status and playback-read bundle for clip_recorder
//   en, start, stop, sample_in : sample strobe, capture control and offset-binary sample (source -> recorder)
//   rd_addr, rd_data           : synchronous playback read port (rd_data is registered, 1-cycle latency)
//   busy, done, full, length   : capture status (recorder -> consumers)
//   modport master             : the sample source / playback side
//   modport slave              : the recorder
interface clip_recorder_if #(
    parameter int AW = 12
);
    logic          en;
    logic          start;
    logic          stop;
    logic [7:0]    sample_in;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          busy;
    logic          done;
    logic          full;
    logic [AW:0]   length;

    modport master (
        output en, start, stop, sample_in, rd_addr,
        input  rd_data, busy, done, full, length
    );

    modport slave (
        input  en, start, stop, sample_in, rd_addr,
        output rd_data, busy, done, full, length
    );
endinterface

// File: rtl/clip_recorder.sv
// rtl/clip_recorder.sv - audio clip capture buffer storing offset-binary samples as two's-complement bytes
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   bus        : clip_recorder_if.slave (capture inputs, status outputs, playback read port)
//   DEPTH / AW : buffer size in samples (power of two) and its log2
//   THRESH     : trigger magnitude compared against the signed sample
//   CLIP_REC_TRIGGER_EN : when defined, start arms the recorder and capture begins at the
//                         first strobed sample whose magnitude reaches THRESH
module clip_recorder #(
    parameter int         DEPTH  = 4096,
    parameter int         AW     = 12,
    parameter logic [7:0] THRESH = 8'd32
) (
    input  logic             clk,
    input  logic             rst,
    clip_recorder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        REC   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

`ifdef CLIP_REC_TRIGGER_EN
    localparam state_t START_STATE = ARMED;
`else
    // ARMED is kept in the encoding but never entered in this build.
    localparam state_t START_STATE = REC;
`endif

    state_t        state, state_d;
    logic [AW:0]   length_q, length_d;
    logic          full_q, full_d;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    s;
    logic [8:0]    mag;
    logic          trig_hit;
    logic [AW:0]   len_inc;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    rd_q;

    // Flipping the MSB turns offset-binary into two's complement (sample_in - 128).
    assign s = {~bus.sample_in[7], bus.sample_in[6:0]};

    // 9-bit magnitude so that -128 maps to +128 rather than wrapping.
    assign mag      = s[7] ? (9'd0 - {1'b1, s}) : {1'b0, s};
    assign trig_hit = (mag >= {1'b0, THRESH});
    assign len_inc  = length_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            length_q <= '0;
            full_q   <= 1'b0;
        end else begin
            state    <= state_d;
            length_q <= length_d;
            full_q   <= full_d;
        end
    end

    always_comb begin
        state_d  = state;
        length_d = length_q;
        full_d   = full_q;
        wr_en    = 1'b0;
        wr_addr  = length_q[AW-1:0];

        case (state)
            IDLE, DONE: begin
                // start takes priority over a coincident stop here; stop alone is ignored.
                if (bus.start) begin
                    length_d = '0;
                    full_d   = 1'b0;
                    state_d  = START_STATE;
                end
            end

            ARMED: begin
                if (bus.en && trig_hit) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    length_d = {{AW{1'b0}}, 1'b1};
                    state_d  = REC;
                end
                if (bus.stop) begin
                    state_d = DONE;
                end
            end

            REC: begin
                if (bus.en) begin
                    wr_en    = 1'b1;
                    length_d = len_inc;
                    // Leaving REC on the DEPTH-th write is what keeps length from wrapping.
                    if (len_inc == DEPTH_L) begin
                        full_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                if (bus.stop) begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sample RAM: no reset so contents survive an aborted capture.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= s;
        end
    end

    // Registered read; a same-address write in this cycle is not forwarded (old data returned).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= 8'd0;
        end else begin
            rd_q <= mem[bus.rd_addr];
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.busy    = (state == ARMED) || (state == REC);
    assign bus.done    = (state == DONE);
    assign bus.full    = full_q;
    assign bus.length  = length_q;

endmodule
